// File: rtl/udp_tx_arb.sv
// udp_tx_arb: frame-level round-robin arbiter in front of a single UDP tx path.
//
// One header is taken from the granted source, registered and offered
// downstream. The same source's payload is then passed straight through until
// its tlast beat, and only then does arbitration run again.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_udp_hdr_*                  per-source header (valid/ready + packed fields)
//   s_udp_payload_axis_*         per-source 8-bit AXI-stream payload
//   m_udp_hdr_*                  registered header to the UDP block
//   m_udp_payload_axis_*         zero-latency payload pass-through
//   grant_index                  source currently owning the path
//   busy                         high while a frame (header or payload) is active

// Per-source handshake gating: each lane decides its own ready bits from
// the shared arbitration result.
module udp_tx_arb_lane #(
  parameter int CL_S_COUNT = 2,
  parameter int IDX        = 0
) (
  input  logic [CL_S_COUNT-1:0] grant_index,
  input  logic [CL_S_COUNT-1:0] sel_idx,
  input  logic                  arb_fire,
  input  logic                  pay_open,
  input  logic                  m_tready,
  output logic                  hdr_ready,
  output logic                  tready
);
  assign hdr_ready = arb_fire && (sel_idx == CL_S_COUNT'(IDX));
  assign tready    = pay_open && (grant_index == CL_S_COUNT'(IDX)) && m_tready;
endmodule

module udp_tx_arb #(
  parameter int S_COUNT    = 4,
  parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [S_COUNT-1:0]      s_udp_hdr_valid,
  output logic [S_COUNT-1:0]      s_udp_hdr_ready,
  input  logic [S_COUNT*32-1:0]   s_udp_ip_dest_ip,
  input  logic [S_COUNT*16-1:0]   s_udp_source_port,
  input  logic [S_COUNT*16-1:0]   s_udp_dest_port,
  input  logic [S_COUNT*16-1:0]   s_udp_length,
  input  logic [S_COUNT*16-1:0]   s_udp_checksum,
  input  logic [S_COUNT*8-1:0]    s_udp_payload_axis_tdata,
  input  logic [S_COUNT-1:0]      s_udp_payload_axis_tvalid,
  output logic [S_COUNT-1:0]      s_udp_payload_axis_tready,
  input  logic [S_COUNT-1:0]      s_udp_payload_axis_tlast,
  input  logic [S_COUNT-1:0]      s_udp_payload_axis_tuser,

  output logic                    m_udp_hdr_valid,
  input  logic                    m_udp_hdr_ready,
  output logic [31:0]             m_udp_ip_dest_ip,
  output logic [15:0]             m_udp_source_port,
  output logic [15:0]             m_udp_dest_port,
  output logic [15:0]             m_udp_length,
  output logic [15:0]             m_udp_checksum,
  output logic [7:0]              m_udp_payload_axis_tdata,
  output logic                    m_udp_payload_axis_tvalid,
  input  logic                    m_udp_payload_axis_tready,
  output logic                    m_udp_payload_axis_tlast,
  output logic                    m_udp_payload_axis_tuser,

  output logic [CL_S_COUNT-1:0]   grant_index,
  output logic                    busy
);

  typedef struct packed {
    logic [31:0] dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_hdr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

  state_t                        state_q, state_d;
  udp_hdr_t [S_COUNT-1:0]        hdr_in;
  udp_hdr_t                      hdr_q;
  logic [S_COUNT-1:0][7:0]       tdata_a;
  logic [CL_S_COUNT-1:0]         last_grant;
  logic [CL_S_COUNT-1:0]         sel_idx;
  logic                          sel_found;
  logic                          arb_fire;
  logic                          pay_open;
  logic                          beat_last;
  int                            arb_idx;

  // unpack the flat per-source buses
  for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
    assign hdr_in[i] = '{dest_ip:     s_udp_ip_dest_ip[i*32 +: 32],
                         source_port: s_udp_source_port[i*16 +: 16],
                         dest_port:   s_udp_dest_port[i*16 +: 16],
                         length:      s_udp_length[i*16 +: 16],
                         checksum:    s_udp_checksum[i*16 +: 16]};
    assign tdata_a[i] = s_udp_payload_axis_tdata[i*8 +: 8];
  end

  // Round robin: scan offsets S_COUNT..1 so the smallest offset from
  // last_grant (highest priority) is the one left standing. Offset S_COUNT is
  // last_grant itself, which therefore has the lowest priority.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    arb_idx   = 0;
    for (int k = S_COUNT; k >= 1; k--) begin
      arb_idx = (int'(last_grant) + k) % S_COUNT;
      if (s_udp_hdr_valid[CL_S_COUNT'(arb_idx)]) begin
        sel_idx   = CL_S_COUNT'(arb_idx);
        sel_found = 1'b1;
      end
    end
  end

  // Handshakes are suppressed while rst is high so nothing is accepted and
  // then discarded by the reset.
  assign arb_fire  = (state_q == ST_IDLE) && sel_found && !rst;
  assign pay_open  = (state_q == ST_PAYLOAD) && !rst;
  assign beat_last = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready &&
                     m_udp_payload_axis_tlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sel_found) state_d = ST_HDR;
      ST_HDR:     if (m_udp_hdr_valid && m_udp_hdr_ready) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (beat_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_grant      <= CL_S_COUNT'(S_COUNT-1);
      grant_index     <= '0;
      m_udp_hdr_valid <= 1'b0;
      hdr_q           <= '0;
    end else begin
      state_q <= state_d;
      if (arb_fire) begin
        hdr_q           <= hdr_in[sel_idx];
        grant_index     <= sel_idx;
        last_grant      <= sel_idx;
        m_udp_hdr_valid <= 1'b1;
      end else if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        m_udp_hdr_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < S_COUNT; i++) begin : g_lane
    udp_tx_arb_lane #(.CL_S_COUNT(CL_S_COUNT), .IDX(i)) u_lane (
      .grant_index (grant_index),
      .sel_idx     (sel_idx),
      .arb_fire    (arb_fire),
      .pay_open    (pay_open),
      .m_tready    (m_udp_payload_axis_tready),
      .hdr_ready   (s_udp_hdr_ready[i]),
      .tready      (s_udp_payload_axis_tready[i])
    );
  end

  assign m_udp_ip_dest_ip  = hdr_q.dest_ip;
  assign m_udp_source_port = hdr_q.source_port;
  assign m_udp_dest_port   = hdr_q.dest_port;
  assign m_udp_length      = hdr_q.length;
  assign m_udp_checksum    = hdr_q.checksum;

  // payload: pure combinational mux of the granted source
  assign m_udp_payload_axis_tdata  = tdata_a[grant_index];
  assign m_udp_payload_axis_tvalid = pay_open && s_udp_payload_axis_tvalid[grant_index];
  assign m_udp_payload_axis_tlast  = s_udp_payload_axis_tlast[grant_index];
  assign m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser[grant_index];

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb (S_COUNT=4): reset values, single frame,
// round robin order, header/payload backpressure, wrap priority, mid-frame
// reset and tuser pass-through.
module tb_udp_tx_arb;
  localparam int S = 4;
  localparam int CL = 2;

  logic            clk = 0;
  logic            rst;
  logic [S-1:0]    s_hdr_valid, s_hdr_ready;
  logic [S*32-1:0] s_dest_ip;
  logic [S*16-1:0] s_sport, s_dport, s_len, s_csum;
  logic [S*8-1:0]  s_tdata;
  logic [S-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic            m_hdr_valid, m_hdr_ready;
  logic [31:0]     m_dest_ip;
  logic [15:0]     m_sport, m_dport, m_len, m_csum;
  logic [7:0]      m_tdata;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic [CL-1:0]   grant;
  logic            busy;

  int tests = 0;
  int fails = 0;

  udp_tx_arb #(.S_COUNT(S)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready),
    .s_udp_ip_dest_ip(s_dest_ip), .s_udp_source_port(s_sport),
    .s_udp_dest_port(s_dport), .s_udp_length(s_len), .s_udp_checksum(s_csum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
    .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_ip_dest_ip(m_dest_ip), .m_udp_source_port(m_sport),
    .m_udp_dest_port(m_dport), .m_udp_length(m_len), .m_udp_checksum(m_csum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tvalid(m_tvalid),
    .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(m_tlast),
    .m_udp_payload_axis_tuser(m_tuser),
    .grant_index(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_payload();
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
  endtask

  // Full frame from source g (hdr_valid set by caller, DUT in IDLE):
  // checks grant pulse, header, then n single-cycle beats; ends back in IDLE.
  task automatic frame(input int g, input int n, input bit user_last);
    logic [S-1:0] onehot;
    onehot = '0;
    onehot[g] = 1'b1;
    check($sformatf("hdr_ready src%0d", g), s_hdr_ready, onehot);
    check("hdr_ready onehot", ($countones(s_hdr_ready) <= 1), 1);
    m_hdr_ready = 1'b1;
    tick();
    check($sformatf("hdr_valid src%0d", g), m_hdr_valid, 1);
    check($sformatf("grant src%0d", g), grant, g);
    check($sformatf("dport src%0d", g), m_dport, s_dport[g*16 +: 16]);
    check($sformatf("no early tvalid src%0d", g), m_tvalid, 0);
    tick();
    m_tready = 1'b1;
    for (int j = 0; j < n; j++) begin
      clr_payload();
      s_tvalid[g] = 1'b1;
      s_tdata[g*8 +: 8] = 8'((g << 4) | j);
      s_tlast[g] = (j == n-1);
      s_tuser[g] = user_last && (j == n-1);
      #1;
      check($sformatf("tdata src%0d b%0d", g, j), m_tdata, (g << 4) | j);
      check($sformatf("tvalid src%0d b%0d", g, j), m_tvalid, 1);
      check($sformatf("tready src%0d b%0d", g, j), s_tready, onehot);
      if (j == n-1) check("tuser last", m_tuser, user_last);
      tick();
    end
    clr_payload();
    check($sformatf("idle after src%0d", g), busy, 0);
  endtask

  initial begin
    int got;
    int cyc;
    rst = 1; s_hdr_valid = '0; m_hdr_ready = 0; m_tready = 0;
    clr_payload();
    for (int i = 0; i < S; i++) begin
      s_dest_ip[i*32 +: 32] = 32'hC0A8_0000 + 32'(i);
      s_sport[i*16 +: 16]   = 16'h2000 + 16'(i);
      s_dport[i*16 +: 16]   = 16'h1000 + 16'(i);
      s_len[i*16 +: 16]     = 16'd8 + 16'(i);
      s_csum[i*16 +: 16]    = 16'hBEE0 + 16'(i);
    end
    tick(); tick();
    rst = 0;
    #1;
    check("rst busy", busy, 0);
    check("rst hdr_valid", m_hdr_valid, 0);
    check("rst grant", grant, 0);
    check("rst hdr_ready", s_hdr_ready, 0);
    check("rst dport", m_dport, 0);
    check("rst dest_ip", m_dest_ip, 0);

    // single source 2
    s_dport[2*16 +: 16] = 16'h1234;
    s_len[2*16 +: 16]   = 16'd12;
    s_hdr_valid = 4'b0100;
    #1;
    check("single hdr_ready", s_hdr_ready, 4'b0100);
    tick();
    s_hdr_valid = '0;
    check("single hdr_valid N+1", m_hdr_valid, 1);
    check("single dport", m_dport, 16'h1234);
    check("single len", m_len, 16'd12);
    check("single busy", busy, 1);
    m_hdr_ready = 1;
    tick();
    m_tready = 1;
    for (int j = 0; j < 4; j++) begin
      s_tvalid[2] = 1; s_tdata[2*8 +: 8] = 8'hA1 + 8'(j); s_tlast[2] = (j == 3);
      #1;
      check($sformatf("single byte%0d", j), m_tdata, 8'hA1 + j);
      check($sformatf("single tlast%0d", j), m_tlast, (j == 3));
      tick();
    end
    clr_payload();
    check("single busy fall", busy, 0);

    // round robin from reset
    rst = 1; tick(); rst = 0;
    s_hdr_valid = 4'b1111;
    #1;
    frame(0, 2, 0);
    frame(1, 2, 0);
    frame(2, 2, 0);
    frame(3, 2, 0);
    frame(0, 2, 0);
    frame(1, 2, 0);
    s_hdr_valid = '0;

    // backpressure: header held 5 cycles, then toggling tready
    m_hdr_ready = 0; m_tready = 0;
    s_hdr_valid = 4'b0010;
    s_dest_ip[1*32 +: 32] = 32'h0A00_0001;
    #1;
    check("bp hdr_ready", s_hdr_ready, 4'b0010);
    tick();
    s_hdr_valid = '0;
    s_tvalid = 4'b1111;
    s_tdata[1*8 +: 8] = 8'hB0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp hdr stable c%0d", c), m_dest_ip, 32'h0A00_0001);
      check($sformatf("bp hdr_valid c%0d", c), m_hdr_valid, 1);
      check($sformatf("bp no beat c%0d", c), {m_tvalid, s_tready}, 0);
      tick();
    end
    m_hdr_ready = 1;
    tick();
    got = 0; cyc = 0;
    while (got < 4 && cyc < 20) begin
      m_tready = (cyc % 2 == 0);
      s_tdata[1*8 +: 8] = 8'hB0 + 8'(got);
      s_tlast[1] = (got == 3);
      #1;
      check($sformatf("bp tdata c%0d", cyc), m_tdata, 8'hB0 + got);
      check($sformatf("bp tready c%0d", cyc), s_tready, m_tready ? 4'b0010 : 4'b0000);
      tick();
      if (m_tready) got++;
      cyc++;
    end
    clr_payload();
    m_tready = 0;
    check("bp beats delivered", got, 4);
    check("bp cycles used", cyc, 7);
    check("bp idle", busy, 0);

    // wrap priority: single-beat frame from 3, then 0 and 2 together -> 0
    s_hdr_valid = 4'b1000;
    #1;
    frame(3, 1, 0);
    s_hdr_valid = 4'b0101;
    #1;
    frame(0, 1, 0);
    s_hdr_valid = '0;

    // reset on the 3rd beat of a 10-byte frame from source 2
    s_hdr_valid = 4'b0100;
    #1;
    check("mrst hdr_ready", s_hdr_ready, 4'b0100);
    tick();
    s_hdr_valid = '0;
    m_hdr_ready = 1;
    tick();
    m_tready = 1;
    s_tvalid[2] = 1;
    for (int j = 0; j < 2; j++) begin
      s_tdata[2*8 +: 8] = 8'(j);
      #1;
      check($sformatf("mrst beat%0d", j), m_tvalid, 1);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("mrst busy", busy, 0);
    check("mrst tvalid", m_tvalid, 0);
    check("mrst hdr_valid", m_hdr_valid, 0);
    check("mrst grant", grant, 0);
    clr_payload();
    s_hdr_valid = 4'b0011;
    #1;
    frame(0, 2, 0);
    s_hdr_valid = '0;

    // error frame from source 1, then arbitration carries on to source 2
    s_hdr_valid = 4'b0010;
    #1;
    frame(1, 3, 1);
    s_hdr_valid = 4'b0100;
    #1;
    frame(2, 1, 0);
    s_hdr_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Frame-level round-robin arbiter sharing the single UDP transmit path (checksum generator / UDP-to-IP encapsulation) between `S_COUNT` independent UDP frame sources. It accepts one UDP header from the granted source, registers it, and presents it downstream. It then passes that source's payload through until the `tlast` beat, and only then re-arbitrates. It sits between application-side UDP sources and the UDP block's `s_udp_*` input.

## Interface
- `S_COUNT`, 4: number of requesting sources, 2..16.
- `CL_S_COUNT`, `$clog2(S_COUNT)`: grant index width.
- `clk` in 1: clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_udp_hdr_valid` in `S_COUNT`: per-source header valid.
- `s_udp_hdr_ready` out `S_COUNT`: per-source header accept; at most one bit is high per cycle.
- `s_udp_ip_dest_ip` in `S_COUNT*32`: packed, source i at `[i*32 +: 32]`.
- `s_udp_source_port`, `s_udp_dest_port`, `s_udp_length`, `s_udp_checksum` in `S_COUNT*16` each: packed the same way.
- `s_udp_payload_axis_tdata` in `S_COUNT*8`; `s_udp_payload_axis_tvalid`, `tlast`, `tuser` in `S_COUNT` each.
- `s_udp_payload_axis_tready` out `S_COUNT`.
- `m_udp_hdr_valid` out 1; `m_udp_hdr_ready` in 1.
- `m_udp_ip_dest_ip` out 32; `m_udp_source_port`, `m_udp_dest_port`, `m_udp_length`, `m_udp_checksum` out 16 each.
- `m_udp_payload_axis_tdata` out 8; `tvalid`, `tlast`, `tuser` out 1; `m_udp_payload_axis_tready` in 1.
- `grant_index` out `CL_S_COUNT`: source currently owning the path.
- `busy` out 1: high in HDR and PAYLOAD states.

## Operation
- State machine with three states: IDLE, HDR, PAYLOAD.
- IDLE
  - If any `s_udp_hdr_valid` bit is set, select the first set bit scanning upward from `(last_grant+1) mod S_COUNT`, with wrap-around.
  - Drive the selected bit of `s_udp_hdr_ready` high for that cycle only.
  - Latch that source's header fields into the output registers, set `grant_index` and `last_grant`, go to HDR.
  - If no bit is set, stay in IDLE.
- HDR
  - `m_udp_hdr_valid`=1 and the header registers are held stable.
  - On `m_udp_hdr_valid && m_udp_hdr_ready`, clear `m_udp_hdr_valid` and go to PAYLOAD.
  - Payload is blocked in this state.
- PAYLOAD
  - Combinational pass-through of the granted source:
    - `m_tdata`/`m_tlast`/`m_tuser` = source fields;
    - `m_tvalid` = `s_tvalid[grant]`;
    - `s_tready[grant]` = `m_tready`.
  - All other `s_tready` bits are 0.
  - On a beat with `tvalid && tready && tlast`, go to IDLE.
- Outside PAYLOAD, all `s_udp_payload_axis_tready` bits are 0 and `m_udp_payload_axis_tvalid` is 0.
- Fairness: a source that has just been served has the lowest priority at the next arbitration. With all sources requesting continuously, the grant order is 0,1,2,…,S_COUNT-1,0.
- `tuser` is passed through unmodified; a frame with `tuser`=1 on `tlast` still ends the grant normally.
- Header valid from non-granted sources is ignored (not acknowledged) until they are selected in IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `last_grant` = `S_COUNT-1`, so source 0 wins first;
  - `grant_index` = 0;
  - `m_udp_hdr_valid` = 0 and `s_udp_hdr_ready` = 0;
  - all header output registers 0;
  - `busy` = 0.
- Header latency:
  - `s_udp_hdr_ready` is high in cycle N, the IDLE arbitration cycle.
  - `m_udp_hdr_valid` is high from N+1.
  - The first payload beat can transfer no earlier than the cycle after the `m_udp_hdr` handshake.
- Inter-frame gap: after the `tlast` handshake in cycle M, the next `s_udp_hdr_ready` occurs no earlier than M+1 (IDLE cycle).
- Payload path has zero latency and no registers; `m_tvalid` may depend combinationally on `s_tvalid`, and `s_tready` on `m_tready`.
- A header request appearing during HDR/PAYLOAD waits; it is never lost and never acknowledged early.
- Single-beat frame (`tlast` on first beat) is legal: one PAYLOAD cycle, then IDLE.
- A source dropping `tvalid` mid-frame stalls the path; there is no timeout and the grant is held.
- `rst` asserted mid-frame:
  - the next cycle is IDLE with all outputs at their reset values;
  - the partially sent frame is truncated with no `tlast`; recovery is the downstream's responsibility;
  - upstream sources must also be reset.

## Test plan
- Single source: source 2 sends header (dest_port 0x1234, length 12) and a 4-byte payload 0xA1..0xA4 with tlast on 0xA4.
  - `s_udp_hdr_ready[2]` pulses at cycle N; `m_udp_hdr_valid` rises at N+1 with `m_udp_dest_port`=0x1234.
  - The 4 bytes appear in order; `busy` falls after the tlast beat.
- Round robin: all 4 sources hold hdr_valid with 2-byte frames continuously.
  - Grant order is 0,1,2,3,0,1.
  - Never two `s_udp_hdr_ready` bits high in one cycle.
- Backpressure:
  - `m_udp_hdr_ready`=0 for 5 cycles: header outputs are stable and no payload beat passes.
  - Then `m_tready` toggles 1,0,1,0 during payload: every byte is delivered exactly once, and non-granted `s_tready`=0 throughout.
- Wrap priority: after granting source 3, sources 0 and 2 request simultaneously -> source 0 is granted next.
- Reset mid-frame: assert `rst` on the 3rd payload beat of a 10-byte frame.
  - Next cycle: `busy`=0, `m_tvalid`=0, `m_udp_hdr_valid`=0, `grant_index`=0.
  - The next request from source 1 and source 0 together grants source 0.
- Error frame: source 1 frame with `tuser`=1 on tlast -> `m_udp_payload_axis_tuser`=1 on that beat, and arbitration resumes normally.
